// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//
// Round-robin arbiter sharing one register-file read port among NREQ
// requesters (e.g. decode Rn, decode Rm, debug/trace). The winning
// requester's address drives the read-mux select. The selected data is
// registered, so the response appears exactly one cycle after the grant.
//
// Data selection for the granted address, highest priority first:
//   1. the zero register always reads as zero (writes to it are never bypassed)
//   2. a same-cycle writeback to the address is forwarded
//   3. otherwise the register-file mux output is used
//
// The response register has no skid buffer. A new read is issued only when
// the register is empty or is being drained in the same cycle.
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 5,
  parameter int DW       = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      req_addr,
  output logic [NREQ-1:0]         gnt,
  output logic [AW-1:0]           rf_read_addr,
  input  logic [DW-1:0]           rf_read_data,
  input  logic                    wb_en,
  input  logic [AW-1:0]           wb_addr,
  input  logic [DW-1:0]           wb_data,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]           rsp_data,
  input  logic                    rsp_ready
);

  localparam int IW = $clog2(NREQ);

  // Architectural state: rotation pointer and the response output register.
  logic [IW-1:0]  r_rr_ptr;
  logic           r_rsp_valid;
  logic [IW-1:0]  r_rsp_id;
  logic [DW-1:0]  r_rsp_data;

  // Combinational arbitration and data-path results.
  logic           w_can_issue;
  logic           w_gnt_any;
  logic [IW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_gnt;
  logic [AW-1:0]  w_rd_addr;
  logic [DW-1:0]  w_sel_data;

  // Requester index (base + off) modulo NREQ. NREQ need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input int unsigned   off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IW'(sum % 32'(NREQ));
  endfunction

  // The output register can accept a new read when it is empty or is being drained now.
  assign w_can_issue = !r_rsp_valid || rsp_ready;

  // Pick the first pending requester at or after the rotation pointer.
  always_comb begin
    // NOTE: every variable written here gets a default first; any path that
    // left one unassigned would make synthesis infer a latch.
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (!reset && w_can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_gnt_any && req[wrap_add(r_rr_ptr, 32'(k))]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = wrap_add(r_rr_ptr, 32'(k));
        end
      end
    end
    if (w_gnt_any) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  // Steer the winner's address to the read-mux select. Drive zero when idle.
  always_comb begin
    w_rd_addr = '0;
    if (w_gnt_any) begin
      w_rd_addr = req_addr[w_gnt_idx*AW +: AW];
    end
  end

  // Apply the zero register, then writeback forwarding, then the register-file data.
  always_comb begin
    if (w_rd_addr == AW'(ZERO_REG)) begin
      w_sel_data = '0;
    end else if (wb_en && (wb_addr == w_rd_addr)) begin
      w_sel_data = wb_data;
    end else begin
      w_sel_data = rf_read_data;
    end
  end

  // Load a granted read, retire an accepted response, or hold while stalled.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every register
    // samples pre-edge values no matter how the statements are ordered.
    if (reset) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_gnt_any) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_data  <= w_sel_data;
      r_rr_ptr    <= wrap_add(w_gnt_idx, 32'd1);
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign gnt          = w_gnt;
  assign rf_read_addr = w_rd_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Round-robin arbiter that shares one 32-entry x 64-bit register-file read port (the 5-bit-select read mux) among NREQ requesters, e.g. decode Rn, decode Rm and the debug/trace port.
- Drives the mux select and registers the mux output, so each response arrives one cycle after grant.
- Applies the zero-register rule and a same-cycle writeback bypass.
- Sits between the ID-stage operand fetch and the register-file read mux.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 5, register address width
- DW, 64, data width
- ZERO_REG, 31, register index that always reads as zero (XZR)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- req  input  NREQ  per-requester read request, held high until granted
- req_addr  input  NREQ*AW  packed register addresses, requester i at bits [i*AW +: AW]
- gnt  output  NREQ  one-hot grant, combinational, at most one bit set
- rf_read_addr  output  AW  select to the register-file read mux
- rf_read_data  input  DW  combinational mux output for rf_read_addr
- wb_en  input  1  writeback write enable for this cycle
- wb_addr  input  AW  writeback register address
- wb_data  input  DW  writeback data
- rsp_valid  output  1  response valid
- rsp_id  output  $clog2(NREQ)  index of the requester the response belongs to
- rsp_data  output  DW  read data
- rsp_ready  input  1  consumer accepts the response

Behaviour:
- Reset (clk edge with reset=1):
  - rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - While reset is high: gnt=0 and rf_read_addr=0.
  - Reset mid-transaction drops any pending response; no grant is issued on the reset cycle.
- can_issue = !rsp_valid || rsp_ready. This is a skid-free output register.
- Grant (combinational):
  - When can_issue is high and req is not zero, grant the first set req bit found scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Otherwise gnt=0.
- rf_read_addr:
  - Equals req_addr of the granted requester.
  - Equals 0 when nothing is granted.
- Data select for the granted address A, in priority order:
  - A==ZERO_REG gives 0.
  - Else, wb_en && wb_addr==A gives wb_data.
  - Else, rf_read_data.
  - A write to ZERO_REG is never bypassed.
- Clock edge with a grant to index g:
  - rsp_valid<=1, rsp_id<=g, rsp_data<=selected data.
  - rr_ptr<=(g+1) mod NREQ.
- Clock edge without a grant:
  - If rsp_valid && rsp_ready, rsp_valid<=0. rsp_id and rsp_data hold their values.
  - If rsp_valid && !rsp_ready, all output registers hold and rr_ptr holds.
- Latency: exactly 1 cycle from gnt to rsp_valid. Throughput is 1 read per cycle while rsp_ready=1.
- Back-to-back: when rsp_ready=1 and a grant occur in the same cycle, the old response retires and the new one loads on that edge. rsp_valid stays 1.
- Requester contract:
  - A requester deasserts req, or presents a new address, the cycle after its gnt.
  - Keeping req high issues a new read.
  - req_addr must be stable while req is high and not yet granted.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- rr_ptr advances only on a grant. The arbiter does not track cycles without a grant.

Test Plan:
1. Reset, then req=3'b001, addr0=5, rf_read_data=64'hA5: gnt=001 and rf_read_addr=5 in cycle 0. Next cycle rsp_valid=1, rsp_id=0, rsp_data=64'hA5.
2. req=3'b111 held for 6 cycles, rsp_ready=1: gnt sequence is 001,010,100,001,010,100, and rsp_id lags gnt by 1 cycle.
3. addr1=31 with rf_read_data=64'hFFFF and wb_en=1, wb_addr=31, wb_data=7: rsp_data=0.
4. addr2=9 with wb_en=1, wb_addr=9, wb_data=64'hDEAD, rf_read_data=64'h1234: rsp_data=64'hDEAD. Repeat with wb_addr=8: rsp_data=64'h1234.
5. rsp_valid=1 and rsp_ready=0 for 3 cycles with req=3'b110: gnt=0, and rsp_valid, rsp_id and rsp_data are unchanged. When rsp_ready rises, gnt=010 in that same cycle and the new response appears next cycle.
6. Mid-stream reset, asserted 1 cycle after a grant with req=3'b111: next cycle rsp_valid=0 and rsp_data=0. After release, the first grant goes to requester 0.
